// File: rtl/alu_share_pkg.sv
// Shared types and helpers for the ALU sharing controller.
package alu_share_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} share_state_t;

    localparam int unsigned MAX_NREQ  = 8;
    localparam int unsigned MAX_IDX_W = 3;

    function automatic logic [MAX_NREQ-1:0] onehot(input logic [MAX_IDX_W-1:0] idx);
        logic [MAX_NREQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/alu_share_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: search starts just after the last winner and wraps.
module rr_arbiter #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last,
    output logic            valid,
    output logic [IW-1:0]   winner
);

    int unsigned idx;

    always_comb begin
        valid  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx = (32'(last) + k) % NREQ;
            if (!valid && req[idx[IW-1:0]]) begin
                valid  = 1'b1;
                winner = idx[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// Round-robin controller sharing one picoMIPS ALU between NREQ requesters.
// Optional macro ALU_SHARE_B2B_EN: RESP also arbitrates for back-to-back issue.
module alu_share_ctrl
    import alu_share_pkg::*;
#(
    parameter int unsigned n    = 8,
    parameter int unsigned NREQ = 2
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   req_mul,
    input  logic [NREQ*n-1:0] req_a,
    input  logic [NREQ*n-1:0] req_b,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   done,
    output logic [n-1:0]      rsp_data,
    output logic              busy,
    output logic [n-1:0]      DataA,
    output logic [n-1:0]      DataB,
    output logic              WriteEn,
    output logic              UseMul,
    input  logic [n-1:0]      alu_result
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    share_state_t state_q, state_d;
    logic [n-1:0]  op_a_q, op_b_q;
    logic          mul_q;
    logic [IW-1:0] own_q, last_q;

    logic          arb_valid, load;
    logic [IW-1:0] win;
    logic [n-1:0]  win_a, win_b;
    logic          win_mul;
    logic [MAX_NREQ-1:0] win_oh, own_oh;

    rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
        .req    (req),
        .last   (last_q),
        .valid  (arb_valid),
        .winner (win)
    );

    assign win_oh = onehot(MAX_IDX_W'(win));
    assign own_oh = onehot(MAX_IDX_W'(own_q));

    always_comb begin
        win_a   = '0;
        win_b   = '0;
        win_mul = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (win == IW'(i)) begin
                win_a   = req_a[i*n +: n];
                win_b   = req_b[i*n +: n];
                win_mul = req_mul[i];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        done     = '0;
        rsp_data = '0;
        WriteEn  = 1'b0;
        busy     = 1'b0;
        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    load    = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                WriteEn = 1'b1;
                busy    = 1'b1;
                state_d = RESP;
            end
            RESP: begin
                busy     = 1'b1;
                done     = own_oh[NREQ-1:0];
                rsp_data = alu_result;
                state_d  = IDLE;
`ifdef ALU_SHARE_B2B_EN
                // Overlap the next grant with this done; result already captured by the ALU.
                if (arb_valid) begin
                    load    = 1'b1;
                    state_d = ISSUE;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
        gnt = load ? win_oh[NREQ-1:0] : '0;
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q <= IDLE;
            op_a_q  <= '0;
            op_b_q  <= '0;
            mul_q   <= 1'b0;
            own_q   <= '0;
            last_q  <= IW'(NREQ - 1);
        end else begin
            state_q <= state_d;
            if (load) begin
                op_a_q <= win_a;
                op_b_q <= win_b;
                mul_q  <= win_mul;
                own_q  <= win;
                last_q <= win;
            end
        end
    end

    assign DataA  = op_a_q;
    assign DataB  = op_b_q;
    assign UseMul = mul_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Self-checking bench for alu_share_ctrl: schedule-based reference model plus a stand-in ALU.
module tb_alu_share_ctrl;

    localparam int N  = 8;
    localparam int NR = 2;
`ifdef ALU_SHARE_B2B_EN
    localparam int GAP = 2;
`else
    localparam int GAP = 3;
`endif

    logic           clk = 1'b0;
    logic           Reset;
    logic [NR-1:0]   req, req_mul, gnt, done;
    logic [NR*N-1:0] req_a, req_b;
    logic [N-1:0]    rsp_data, DataA, DataB, alu_result;
    logic            busy, WriteEn, UseMul;

    always #5 clk = ~clk;

    alu_share_ctrl #(.n(N), .NREQ(NR)) dut (
        .clk        (clk),
        .Reset      (Reset),
        .req        (req),
        .req_mul    (req_mul),
        .req_a      (req_a),
        .req_b      (req_b),
        .gnt        (gnt),
        .done       (done),
        .rsp_data   (rsp_data),
        .busy       (busy),
        .DataA      (DataA),
        .DataB      (DataB),
        .WriteEn    (WriteEn),
        .UseMul     (UseMul),
        .alu_result (alu_result)
    );

    // Stand-in ALU: registers its result when WriteEn is high.
    always @(posedge clk) begin
        if (WriteEn) alu_result <= UseMul ? N'(DataA * DataB) : N'(DataA + DataB);
    end

    int total = 0;
    int bad   = 0;

    // Reference model: a grant at cycle g means ISSUE at g+1, done at g+2,
    // and the next grant is possible from g+GAP on.
    int       cyc = 0;
    int       next_free = 0;
    bit       inflight = 0;
    int       gcyc = 0;
    int       own = 0;
    int       lw = NR - 1;
    int       model_win = -1;
    logic [N-1:0] ra = '0, rb = '0, res_e = '0;
    logic         rm = 1'b0;

    logic [NR-1:0] o_gnt, o_done;
    logic [N-1:0]  o_rsp;
    logic          o_we, o_mul;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, obs, exp_v);
        end
    endtask

    task automatic cycle();
        logic [NR-1:0] e_gnt, e_done;
        logic [N-1:0]  e_rsp;
        logic          e_we, e_busy;
        int            w;
        w = -1;
        if (cyc >= next_free) begin
            for (int k = 1; k <= NR; k++) begin
                int idx;
                idx = (lw + k) % NR;
                if (w < 0 && req[idx]) w = idx;
            end
        end
        e_gnt = '0;
        if (w >= 0) e_gnt[w] = 1'b1;
        e_we   = inflight && (cyc == gcyc + 1);
        e_done = '0;
        e_rsp  = '0;
        if (inflight && (cyc == gcyc + 2)) begin
            e_done[own] = 1'b1;
            e_rsp       = res_e;
        end
        e_busy = inflight && ((cyc == gcyc + 1) || (cyc == gcyc + 2));

        @(negedge clk);
        chk("gnt", 32'(gnt), 32'(e_gnt));
        chk("done", 32'(done), 32'(e_done));
        chk("rsp_data", 32'(rsp_data), 32'(e_rsp));
        chk("WriteEn", 32'(WriteEn), 32'(e_we));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("DataA", 32'(DataA), 32'(ra));
        chk("DataB", 32'(DataB), 32'(rb));
        chk("UseMul", 32'(UseMul), 32'(rm));
        o_gnt = gnt; o_done = done; o_rsp = rsp_data; o_we = WriteEn; o_mul = UseMul;

        @(posedge clk);
        model_win = -1;
        if (Reset) begin
            inflight  = 0;
            ra = '0; rb = '0; rm = 1'b0;
            lw        = NR - 1;
            next_free = cyc + 1;
        end else begin
            if (inflight && (cyc == gcyc + 2)) inflight = 0;
            if (w >= 0) begin
                model_win = w;
                inflight  = 1;
                gcyc      = cyc;
                own       = w;
                lw        = w;
                ra        = req_a[w*N +: N];
                rb        = req_b[w*N +: N];
                rm        = req_mul[w];
                res_e     = rm ? N'(ra * rb) : N'(ra + rb);
                next_free = cyc + GAP;
            end
        end
        cyc++;
        #1;
    endtask

    task automatic set_op(input int i, input logic m, input logic [N-1:0] a, input logic [N-1:0] b);
        req[i]         = 1'b1;
        req_mul[i]     = m;
        req_a[i*N +: N] = a;
        req_b[i*N +: N] = b;
    endtask

    task automatic do_reset(input int cycles);
        Reset = 1'b1;
        req   = '0;
        for (int k = 0; k < cycles; k++) cycle();
        Reset = 1'b0;
    endtask

    initial begin
        int gcount;
        int gcyc_list[4];
        logic [NR-1:0] gval[4];

        Reset = 1'b1; req = '0; req_mul = '0; req_a = '0; req_b = '0;
        @(posedge clk); #1;

        // 1: reset then idle
        do_reset(2);
        for (int k = 0; k < 5; k++) cycle();
        chk("t1_busy", 32'(busy), 32'd0);

        // 2: requester 0 add
        set_op(0, 1'b0, 8'h05, 8'h03);
        cycle();
        chk("t2_gnt", 32'(o_gnt), 32'h1);
        req = '0;
        cycle();
        chk("t2_we", 32'(o_we), 32'h1);
        chk("t2_mul", 32'(o_mul), 32'h0);
        cycle();
        chk("t2_done", 32'(o_done), 32'h1);
        chk("t2_rsp", 32'(o_rsp), 32'h08);
        for (int k = 0; k < 2; k++) cycle();

        // 3: requester 1 multiply, negative operand
        set_op(1, 1'b1, 8'hFD, 8'h04);
        cycle();
        chk("t3_gnt", 32'(o_gnt), 32'h2);
        req = '0;
        cycle();
        chk("t3_mul", 32'(o_mul), 32'h1);
        cycle();
        chk("t3_done", 32'(o_done), 32'h2);
        chk("t3_rsp", 32'(o_rsp), 32'hF4);
        for (int k = 0; k < 2; k++) cycle();

        // 4: both held from reset, alternating grants spaced GAP apart
        set_op(0, 1'b0, 8'h11, 8'h22);
        set_op(1, 1'b1, 8'h07, 8'h09);
        Reset = 1'b1;
        cycle();
        Reset = 1'b0;
        gcount = 0;
        for (int k = 0; k < 20 && gcount < 4; k++) begin
            cycle();
            if (o_gnt != '0) begin
                gcyc_list[gcount] = cyc;
                gval[gcount]      = o_gnt;
                gcount++;
            end
        end
        chk("t4_grants", 32'(gcount), 32'd4);
        for (int k = 0; k < gcount; k++) begin
            chk("t4_order", 32'(gval[k]), (k % 2 == 0) ? 32'h1 : 32'h2);
            if (k > 0) chk("t4_gap", 32'(gcyc_list[k] - gcyc_list[k-1]), 32'(GAP));
        end
        req = '0;
        for (int k = 0; k < 4; k++) cycle();

        // 5: reset during ISSUE drops the op; requester 0 wins afterwards
        set_op(1, 1'b0, 8'h40, 8'h02);
        cycle();
        chk("t5_gnt", 32'(o_gnt), 32'h2);
        req   = '0;
        Reset = 1'b1;
        cycle();
        Reset = 1'b0;
        cycle();
        chk("t5_nodone", 32'(o_done), 32'h0);
        set_op(0, 1'b0, 8'h01, 8'h01);
        set_op(1, 1'b0, 8'h02, 8'h02);
        cycle();
        chk("t5_prio", 32'(o_gnt), 32'h1);
        req = '0;
        for (int k = 0; k < 4; k++) cycle();

        // 6: requester 1 drops its request before it is arbitrated
        set_op(0, 1'b0, 8'h10, 8'h20);
        cycle();
        set_op(1, 1'b1, 8'h03, 8'h03);
        cycle();
        req[1] = 1'b0;
        for (int k = 0; k < 8; k++) begin
            cycle();
            chk("t6_no1", 32'(o_gnt[1] | o_done[1]), 32'h0);
        end
        req = '0;
        for (int k = 0; k < 4; k++) cycle();

        // Random traffic against the model
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < NR; i++) begin
                if (model_win == i) begin
                    req[i] = 1'b0;
                    if ($urandom_range(0, 1) == 0)
                        set_op(i, 1'($urandom), 8'($urandom), 8'($urandom));
                end else if (!req[i] && $urandom_range(0, 3) == 0) begin
                    set_op(i, 1'($urandom), 8'($urandom), 8'($urandom));
                end else if (req[i] && $urandom_range(0, 19) == 0) begin
                    req[i] = 1'b0;
                end
            end
            Reset = ($urandom_range(0, 149) == 0);
            cycle();
        end
        Reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_share_ctrl.md
Name: alu_share_ctrl

Overview:
- Round-robin controller that shares one picoMIPS ALU instance between NREQ requesters.
- Accepts add/multiply requests, latches the operands, and drives the ALU's DataA, DataB, WriteEn and UseMul inputs.
- Returns the registered ALU result to the winning requester with a one-cycle done pulse.
- Sits between the requesting units (decode/execute, address generator) and the ALU.

Parameters:
- n, 8: operand/result width; must match the ALU's n.
- NREQ, 2: number of requesters; 2..8.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- Reset  in  1  synchronous reset, active high.
- req  in  NREQ  per-requester request; held high until gnt.
- req_mul  in  NREQ  per-requester op select: 1 = multiply, 0 = add.
- req_a  in  NREQ*n  operand A, requester i at bits [i*n +: n].
- req_b  in  NREQ*n  operand B, same packing as req_a.
- gnt  out  NREQ  one-hot grant pulse; operands are latched in this cycle.
- done  out  NREQ  one-hot completion pulse.
- rsp_data  out  n  ALU result; valid while any done bit is high.
- busy  out  1  high in ISSUE and RESP.
- DataA  out  n  to ALU DataA.
- DataB  out  n  to ALU DataB.
- WriteEn  out  1  to ALU WriteEn.
- UseMul  out  1  to ALU UseMul.
- alu_result  in  n  from ALU result (registered inside the ALU).

Behaviour:
- States: IDLE, ISSUE, RESP.
- IDLE:
  - If any req is high, the arbiter picks winner w.
  - gnt[w]=1 combinationally in this cycle.
  - At the clock edge: opA_q<=req_a[w], opB_q<=req_b[w], mul_q<=req_mul[w], own_q<=w, last_q<=w; go to ISSUE.
  - If no req is high, stay in IDLE.
- ISSUE: WriteEn=1 for exactly this cycle, so the ALU registers its result at the end of this cycle. Go to RESP unconditionally.
- RESP: done[own_q]=1, rsp_data=alu_result. Go to IDLE.
- Latency: gnt in cycle t, done in cycle t+2. Throughput is 1 op per 3 cycles.
- Operand outputs: DataA=opA_q, DataB=opB_q and UseMul=mul_q are driven from registers in every state; they are stable throughout ISSUE.
- Round-robin arbitration:
  - Search starts at (last_q+1) mod NREQ and wraps; the first requester found with req high wins.
  - last_q resets to NREQ-1, so requester 0 has priority first after reset.
- Requests outside IDLE: req is ignored in ISSUE and RESP, and gnt stays 0 there. A requester that drops req before its gnt is simply not served.
- Same requester: done[i] and a new req[i] may be high in the same cycle. The new request is arbitrated in the next IDLE cycle.
- Arithmetic: the controller does no arithmetic. Width, wrap and overflow behaviour is entirely the ALU's.
- Outputs are 0 whenever not in their active state.
- Reset:
  - Sampled at the clock edge, including mid-operation.
  - Next state is IDLE; opA_q, opB_q, mul_q, own_q are 0; last_q is NREQ-1.
  - gnt, done, WriteEn, busy are 0 and rsp_data is 0 in the cycle after reset.
  - An operation in flight is dropped and no done is issued for it.

Optional Feature:
- Macro: ALU_SHARE_B2B_EN.
- Defined:
  - RESP also arbitrates. If any req is high, gnt[w] pulses in the RESP cycle (alongside done[own_q]), operands are latched, and the next state is ISSUE instead of IDLE.
  - Sustained throughput is 1 op per 2 cycles. busy stays high across back-to-back ops.
  - The requester currently receiving done is eligible, subject to round-robin order.
- Undefined: RESP always goes to IDLE, as described in Behaviour.

Decomposition:
- Package alu_share_pkg holds:
  - typedef enum logic [1:0] {IDLE, ISSUE, RESP} share_state_t;
  - localparam MAX_NREQ = 8;
  - function onehot(idx), used for the gnt/done encoding.
- One sub-module: rr_arbiter.
  - Combinational, parameter NREQ.
  - Inputs: req, last.
  - Outputs: valid, winner index.

Test Plan:
1. Reset held 2 cycles, then req=00 for 5 cycles -> all outputs 0, state IDLE, busy=0.
2. NREQ=2, n=8, req=01, req_mul[0]=0, A0=8'h05, B0=8'h03 -> gnt=01 at t, WriteEn=1 and UseMul=0 at t+1, done=01 with rsp_data=8'h08 at t+2.
3. req=10, req_mul[1]=1, A1=8'hFD (-3), B1=8'h04 -> done=10 at t+2 with rsp_data=8'hF4 (-12), UseMul=1 in ISSUE.
4. req=11 held continuously from reset -> grants alternate 01,10,01,10, spaced 3 cycles apart (2 cycles with ALU_SHARE_B2B_EN); no starvation.
5. Reset asserted in the ISSUE cycle -> no done for that op, next cycle IDLE; a new req=01 is granted with requester 0 priority.
6. req[1] dropped one cycle before arbitration while req[0] is held -> only requester 0 is granted; no gnt[1] or done[1] appears.
